jtsimson_palout: RTL and testbench

JTSIMSON_PALOUT -- requirements
Module: jtsimson_palout

---
 rtl/jtsimson_palout.sv | 141 ++++++++++++++
 tb/tb_jtsimson_palout.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jtsimson_palout.sv
// Palette RAM (CPU byte port + video word port) with shadow/highlight colour processing.
// One pixel of latency: index latched on pxl_cen, RGB presented on the following pxl_cen.
module jtsimson_palout (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    // CPU side
    input  logic        pal_cs,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  pal_dout,
    // mixer side
    input  logic [10:0] cout,
    input  logic        col_n,
    input  logic [1:0]  shd,
    input  logic        brit,
    input  logic        brit_en,
    input  logic        LHBL,
    input  logic        LVBL,
    // video out
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        LHBL_dly,
    output logic        LVBL_dly
);

    logic [15:0] pal_ram [0:2047];

    // stage 1: latched on pxl_cen
    logic [10:0] idx_l;
    logic [1:0]  shd_l;
    logic        brit_l, lhbl_l, lvbl_l;
    logic        vld1;
    // stage 2: palette word read back
    logic [14:0] vdata;
    logic [1:0]  shd_2;
    logic        brit_2, lhbl_2, lvbl_2;
    logic        vld2;
    // stage 3: processed colour
    logic [4:0]  pr_r, pr_g, pr_b;
    logic        pr_lhbl, pr_lvbl;

    logic [10:0] cpu_word;
    logic        cpu_wr;

    assign cpu_word = cpu_addr[11:1];
    assign cpu_wr   = rst_n & pal_cs & cpu_we;

    function automatic logic [4:0] shade(input logic [4:0] c, input logic [1:0] s,
                                         input logic br, input logic blank);
        logic [4:0] res;
        res = c;
        if (blank)
            res = 5'd0;
        else if (s == 2'b00)
            res = c >> 1;
        else if (s != 2'b11)
            res = c - (c >> 2);
        else if (br)
            res = c + ((5'd31 - c) >> 1);
        return res;
    endfunction

    function automatic logic [7:0] expand(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    // RAM contents survive reset; only CPU writes are gated by it
    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            if (cpu_addr[0])
                pal_ram[cpu_word][7:0]  <= cpu_dout;
            else
                pal_ram[cpu_word][15:8] <= cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pal_dout <= 8'd0;
            idx_l    <= 11'd0;
            shd_l    <= 2'd0;
            brit_l   <= 1'b0;
            lhbl_l   <= 1'b0;
            lvbl_l   <= 1'b0;
            vld1     <= 1'b0;
            vdata    <= 15'd0;
            shd_2    <= 2'd0;
            brit_2   <= 1'b0;
            lhbl_2   <= 1'b0;
            lvbl_2   <= 1'b0;
            vld2     <= 1'b0;
            pr_r     <= 5'd0;
            pr_g     <= 5'd0;
            pr_b     <= 5'd0;
            pr_lhbl  <= 1'b0;
            pr_lvbl  <= 1'b0;
            red      <= 8'd0;
            green    <= 8'd0;
            blue     <= 8'd0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else begin
            pal_dout <= cpu_addr[0] ? pal_ram[cpu_word][7:0] : pal_ram[cpu_word][15:8];
            vld1     <= pxl_cen;
            vld2     <= vld1;
            if (pxl_cen) begin
                idx_l  <= col_n ? 11'd0 : cout;
                shd_l  <= shd;
                brit_l <= brit & brit_en;
                lhbl_l <= LHBL;
                lvbl_l <= LVBL;
            end
            // single read per pixel: a same-clk CPU write is seen only by later pixels
            if (vld1) begin
                vdata  <= pal_ram[idx_l][14:0];
                shd_2  <= shd_l;
                brit_2 <= brit_l;
                lhbl_2 <= lhbl_l;
                lvbl_2 <= lvbl_l;
            end
            if (vld2) begin
                pr_r    <= shade(vdata[4:0],   shd_2, brit_2, ~(lhbl_2 & lvbl_2));
                pr_g    <= shade(vdata[9:5],   shd_2, brit_2, ~(lhbl_2 & lvbl_2));
                pr_b    <= shade(vdata[14:10], shd_2, brit_2, ~(lhbl_2 & lvbl_2));
                pr_lhbl <= lhbl_2;
                pr_lvbl <= lvbl_2;
            end
            if (pxl_cen) begin
                red      <= expand(pr_r);
                green    <= expand(pr_g);
                blue     <= expand(pr_b);
                LHBL_dly <= pr_lhbl;
                LVBL_dly <= pr_lvbl;
            end
        end
    end

endmodule

// File: tb/tb_jtsimson_palout.sv
// Directed bench for jtsimson_palout: palette writes, shading modes, blanking, collisions, reset.
module tb_jtsimson_palout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pxl_cen;
    logic        pal_cs;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  pal_dout;
    logic [10:0] cout;
    logic        col_n;
    logic [1:0]  shd;
    logic        brit;
    logic        brit_en;
    logic        LHBL;
    logic        LVBL;
    logic [7:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly;

    int passed = 0;
    int total  = 0;

    jtsimson_palout dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .pal_cs   (pal_cs),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .cout     (cout),
        .col_n    (col_n),
        .shd      (shd),
        .brit     (brit),
        .brit_en  (brit_en),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    always #5 clk = ~clk;

    task automatic write_byte(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pal_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_dout = d;
        @(negedge clk);
        pal_cs = 1'b0; cpu_we = 1'b0;
    endtask

    // one pixel period of 4 clk; returns at a negedge, 4 clk after the pxl_cen edge
    task automatic pix(input logic [10:0] idx, input logic cn, input logic [1:0] s,
                       input logic b, input logic be, input logic hb, input logic vb);
        @(negedge clk);
        cout = idx; col_n = cn; shd = s; brit = b; brit_en = be; LHBL = hb; LVBL = vb;
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pxl_cen = 1'b0; pal_cs = 1'b0; cpu_we = 1'b0;
        cpu_addr = 12'd0; cpu_dout = 8'd0; cout = 11'd0; col_n = 1'b0;
        shd = 2'b11; brit = 1'b0; brit_en = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        repeat (4) @(negedge clk);
        total++; if ({red, green, blue} !== 24'd0) $display("FAIL reset_rgb got %h want 000000", {red, green, blue}); else passed++;
        total++; if ({LHBL_dly, LVBL_dly} !== 2'b00) $display("FAIL reset_dly got %b want 00", {LHBL_dly, LVBL_dly}); else passed++;
        total++; if (pal_dout !== 8'd0) $display("FAIL reset_pal_dout got %h want 00", pal_dout); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_white;
        write_byte(12'h002, 8'h7F);
        write_byte(12'h003, 8'hFF);
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        total++; if ({red, green, blue} !== 24'd0) $display("FAIL first_pix_after_reset got %h want 000000", {red, green, blue}); else passed++;
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        total++; if ({red, green, blue} !== 24'hFFFFFF) $display("FAIL white_rgb got %h want FFFFFF", {red, green, blue}); else passed++;
        total++; if ({LHBL_dly, LVBL_dly} !== 2'b11) $display("FAIL white_dly got %b want 11", {LHBL_dly, LVBL_dly}); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({red, green, blue} !== 24'hFFFFFF) $display("FAIL hold_between_cen got %h want FFFFFF", {red, green, blue}); else passed++;
    endtask

    task automatic test_shade;
        write_byte(12'h00A, 8'h00);
        write_byte(12'h00B, 8'h10);
        pix(11'd5, 0, 2'b00, 0, 0, 1, 1);
        pix(11'd5, 0, 2'b01, 0, 0, 1, 1);
        total++; if ({red, green, blue} !== 24'h420000) $display("FAIL shd00 got %h want 420000", {red, green, blue}); else passed++;
        pix(11'd5, 0, 2'b11, 1, 1, 1, 1);
        total++; if (red !== 8'h63) $display("FAIL shd01 got %h want 63", red); else passed++;
        pix(11'd5, 0, 2'b11, 1, 0, 1, 1);
        total++; if (red !== 8'hBD) $display("FAIL brit got %h want BD", red); else passed++;
        pix(11'd5, 0, 2'b10, 0, 0, 1, 1);
        total++; if (red !== 8'h84) $display("FAIL brit_dis got %h want 84", red); else passed++;
        pix(11'd1, 0, 2'b11, 1, 1, 1, 1);
        total++; if (red !== 8'h63) $display("FAIL shd10 got %h want 63", red); else passed++;
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        total++; if ({red, green, blue} !== 24'hFFFFFF) $display("FAIL brit_sat got %h want FFFFFF", {red, green, blue}); else passed++;
    endtask

    task automatic test_backdrop;
        write_byte(12'h000, 8'h00);
        write_byte(12'h001, 8'h1F);
        pix(11'h123, 1, 2'b11, 0, 0, 1, 1);
        pix(11'h123, 1, 2'b11, 0, 0, 1, 1);
        total++; if ({red, green, blue} !== 24'hFF0000) $display("FAIL backdrop got %h want FF0000", {red, green, blue}); else passed++;
    endtask

    task automatic test_blank;
        pix(11'd1, 0, 2'b11, 0, 0, 1, 0);
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        total++; if ({red, green, blue} !== 24'd0) $display("FAIL vblank_rgb got %h want 000000", {red, green, blue}); else passed++;
        total++; if ({LHBL_dly, LVBL_dly} !== 2'b10) $display("FAIL vblank_dly got %b want 10", {LHBL_dly, LVBL_dly}); else passed++;
        pix(11'd1, 0, 2'b11, 0, 0, 0, 1);
        total++; if ({red, LVBL_dly} !== {8'hFF, 1'b1}) $display("FAIL unblank got %h/%b want FF/1", red, LVBL_dly); else passed++;
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        total++; if ({red, LHBL_dly} !== {8'h00, 1'b0}) $display("FAIL hblank got %h/%b want 00/0", red, LHBL_dly); else passed++;
    endtask

    task automatic test_collision;
        write_byte(12'h00E, 8'h00);
        write_byte(12'h00F, 8'h1F);
        @(negedge clk);
        cout = 11'd7; col_n = 1'b0; shd = 2'b11; brit = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        pal_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h00F; cpu_dout = 8'h00;
        @(negedge clk);
        pal_cs = 1'b0; cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        pix(11'd7, 0, 2'b11, 0, 0, 1, 1);
        total++; if (red !== 8'hFF) $display("FAIL collide_old got %h want FF", red); else passed++;
        pix(11'd7, 0, 2'b11, 0, 0, 1, 1);
        total++; if (red !== 8'h00) $display("FAIL collide_new got %h want 00", red); else passed++;
    endtask

    task automatic test_reset_mid;
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        @(negedge clk);
        cout = 11'd1; pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0; rst_n = 1'b0;
        pal_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h003; cpu_dout = 8'h00;
        @(negedge clk);
        total++; if ({red, green, blue} !== 24'd0) $display("FAIL midrst_rgb got %h want 000000", {red, green, blue}); else passed++;
        total++; if ({LHBL_dly, LVBL_dly, pal_dout} !== 10'd0) $display("FAIL midrst_misc got %h want 000", {LHBL_dly, LVBL_dly, pal_dout}); else passed++;
        rst_n = 1'b1; pal_cs = 1'b0; cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        total++; if ({red, LVBL_dly} !== 9'd0) $display("FAIL midrst_discard got %h/%b want 00/0", red, LVBL_dly); else passed++;
        pix(11'd1, 0, 2'b11, 0, 0, 1, 1);
        total++; if ({red, green, blue} !== 24'hFFFFFF) $display("FAIL midrst_recover got %h want FFFFFF", {red, green, blue}); else passed++;
        cpu_addr = 12'h003;
        @(negedge clk);
        total++; if (pal_dout !== 8'hFF) $display("FAIL readback_lo got %h want FF", pal_dout); else passed++;
        cpu_addr = 12'h002;
        @(negedge clk);
        total++; if (pal_dout !== 8'h7F) $display("FAIL readback_hi got %h want 7F", pal_dout); else passed++;
        cpu_addr = 12'h00B;
        @(negedge clk);
        total++; if (pal_dout !== 8'h10) $display("FAIL readback_w5 got %h want 10", pal_dout); else passed++;
    endtask

    initial begin
        test_reset;
        test_white;
        test_shade;
        test_backdrop;
        test_blank;
        test_collision;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
